// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu.
// The master side issues operands and consumes results; the ALU is the slave.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [4:0]       Card;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;
    logic [WIDTH-1:0] H;
    logic             Cout;
    logic             Zero;
    logic             Neg;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, Card, out_ready,
        input  in_ready, out_valid, F, H, Cout, Zero, Neg, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, Card, out_ready,
        output in_ready, out_valid, F, H, Cout, Zero, Neg, Ovf
    );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with N/Z/C/V flags, shifts and an iterative shift-add unsigned multiplier.
// state | meaning
// IDLE  | waiting for an operand bundle
// BUSY  | multiplier iterating, one partial product per clock
// DONE  | result registers valid, held until the consumer takes them
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_alu_if.slave  bus
);
    localparam int         SHW    = $clog2(WIDTH);
    localparam logic [4:0] OP_MUL = 5'b10100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic             in_ready, accept, is_mul;
    logic [SHW-1:0]   cnt, shamt;
    logic [WIDTH-1:0] mcand, mp_hi, mp_lo;
    logic [WIDTH:0]   mp_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH-1:0] f_q, h_q;
    logic             cout_q, zero_q, neg_q, ovf_q;

    logic [WIDTH-1:0] alu_f, ax, ay;
    logic [WIDTH:0]   asum;
    logic             aci, arith, valid_op;
    logic             alu_cout, alu_zero, alu_neg, alu_ovf;

    assign is_mul = (bus.Card == OP_MUL);
    assign accept = in_ready & bus.in_valid;
    assign shamt  = bus.B[SHW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nx = is_mul ? BUSY : DONE;
            end
            BUSY: begin
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    in_ready = 1'b1;
                    if (bus.in_valid) state_nx = is_mul ? BUSY : DONE;
                    else              state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Subtractions are folded into one adder as X + ~Y + carry-in.
    always_comb begin
        alu_f    = '1;
        ax       = '0;
        ay       = '0;
        aci      = 1'b0;
        arith    = 1'b0;
        valid_op = 1'b1;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (bus.Card)
            5'b00001: begin arith = 1'b1; ax = bus.A; ay = bus.B;  aci = 1'b0;     end
            5'b00010: begin arith = 1'b1; ax = bus.A; ay = bus.B;  aci = bus.Cin;  end
            5'b00011: begin arith = 1'b1; ax = bus.A; ay = ~bus.B; aci = 1'b1;     end
            5'b00100: begin arith = 1'b1; ax = bus.A; ay = ~bus.B; aci = ~bus.Cin; end
            5'b00101: begin arith = 1'b1; ax = bus.B; ay = ~bus.A; aci = 1'b1;     end
            5'b00110: begin arith = 1'b1; ax = bus.B; ay = ~bus.A; aci = ~bus.Cin; end
            5'b00111: alu_f = bus.A;
            5'b01000: alu_f = bus.B;
            5'b01001: alu_f = ~bus.A;
            5'b01010: alu_f = ~bus.B;
            5'b01011: alu_f = bus.A | bus.B;
            5'b01100: alu_f = bus.A & bus.B;
            5'b01101: alu_f = ~(bus.A ^ bus.B);
            5'b01110: alu_f = bus.A ^ bus.B;
            5'b01111: alu_f = ~(bus.A & bus.B);
            5'b10000: alu_f = '0;
            5'b10001: alu_f = bus.A << shamt;
            5'b10010: alu_f = bus.A >> shamt;
            5'b10011: alu_f = $signed(bus.A) >>> shamt;
            OP_MUL:   alu_f = '0;
            default:  valid_op = 1'b0;
        endcase
        asum = {1'b0, ax} + {1'b0, ay} + {{WIDTH{1'b0}}, aci};
        if (arith) begin
            alu_f    = asum[WIDTH-1:0];
            alu_cout = asum[WIDTH];
            alu_ovf  = (ax[WIDTH-1] == ay[WIDTH-1]) && (asum[WIDTH-1] != ax[WIDTH-1]);
        end
        alu_zero = valid_op && (alu_f == '0);
        alu_neg  = valid_op && alu_f[WIDTH-1];
    end

    // Multiplier LSB first: add multiplicand into the high half, then shift {hi, lo} right.
    assign mp_sum = {1'b0, mp_hi} + (mp_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign mul_hi = mp_sum[WIDTH:1];
    assign mul_lo = {mp_sum[0], mp_lo[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            mcand  <= '0;
            mp_hi  <= '0;
            mp_lo  <= '0;
            f_q    <= '0;
            h_q    <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            if (is_mul) begin
                mcand <= bus.A;
                mp_hi <= '0;
                mp_lo <= bus.B;
                cnt   <= SHW'(WIDTH - 1);
            end else begin
                f_q    <= alu_f;
                h_q    <= '0;
                cout_q <= alu_cout;
                zero_q <= alu_zero;
                neg_q  <= alu_neg;
                ovf_q  <= alu_ovf;
            end
        end else if (state == BUSY) begin
            mp_hi <= mul_hi;
            mp_lo <= mul_lo;
            if (cnt == '0) begin
                f_q    <= mul_lo;
                h_q    <= mul_hi;
                cout_q <= 1'b0;
                zero_q <= (mul_lo == '0) && (mul_hi == '0);
                neg_q  <= mul_lo[WIDTH-1];
                ovf_q  <= 1'b0;
            end else begin
                cnt <= cnt - SHW'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.F         = f_q;
    assign bus.H         = h_q;
    assign bus.Cout      = cout_q;
    assign bus.Zero      = zero_q;
    assign bus.Neg       = neg_q;
    assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32: opcode vector table plus multiplier,
// back-pressure and mid-operation reset sequences.
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) bus();
    seq_alu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] f;
        logic [3:0]  flg;   // {Cout, Zero, Neg, Ovf}
    } vec_t;

    vec_t vecs[23];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.Cout, bus.Zero, bus.Neg, bus.Ovf};
    endfunction

    function automatic vec_t mk(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                                logic cin, logic [31:0] f, logic [3:0] flg);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.cin = cin; v.f = f; v.flg = flg;
        return v;
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin);
        bus.Card = op;
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        bus.in_valid = 1'b1;
    endtask

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_h, input logic [31:0] exp_f, input logic [3:0] exp_flg);
        int lat;
        logic busy_ready;
        drive(5'b10100, a, b, 1'b0);
        @(negedge clk);
        check({name, "_accept_busy"}, {63'd0, bus.in_ready}, 64'd0);
        bus.in_valid = 1'b0;
        bus.A = 32'h0;
        bus.B = 32'h0;
        lat = 0;
        busy_ready = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_ready = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd32);
        check({name, "_ready_low_busy"}, {63'd0, busy_ready}, 64'd0);
        check({name, "_H"}, {32'd0, bus.H}, {32'd0, exp_h});
        check({name, "_F"}, {32'd0, bus.F}, {32'd0, exp_f});
        check({name, "_flags"}, {60'd0, flags()}, {60'd0, exp_flg});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(5'b00001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b1100);
        vecs[1]  = mk(5'b00001, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b0011);
        vecs[2]  = mk(5'b00100, 32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 4'b0010);
        vecs[3]  = mk(5'b00101, 32'h00000003, 32'h0000000A, 1'b0, 32'h00000007, 4'b1000);
        vecs[4]  = mk(5'b00010, 32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 4'b0000);
        vecs[5]  = mk(5'b00011, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 4'b0010);
        vecs[6]  = mk(5'b00110, 32'h00000001, 32'h80000000, 1'b0, 32'h7FFFFFFF, 4'b1001);
        vecs[7]  = mk(5'b00111, 32'h12345678, 32'hFFFFFFFF, 1'b1, 32'h12345678, 4'b0000);
        vecs[8]  = mk(5'b01000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h00000000, 4'b0100);
        vecs[9]  = mk(5'b01001, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 4'b0010);
        vecs[10] = mk(5'b01010, 32'h00000000, 32'hF0F0F0F0, 1'b0, 32'h0F0F0F0F, 4'b0000);
        vecs[11] = mk(5'b01011, 32'hF0F00000, 32'h0000F0F0, 1'b0, 32'hF0F0F0F0, 4'b0010);
        vecs[12] = mk(5'b01100, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 32'h0F000F00, 4'b0000);
        vecs[13] = mk(5'b01101, 32'h12345678, 32'h12345678, 1'b0, 32'hFFFFFFFF, 4'b0010);
        vecs[14] = mk(5'b01110, 32'hAAAA5555, 32'hFFFF0000, 1'b0, 32'h55555555, 4'b0000);
        vecs[15] = mk(5'b01111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4'b0100);
        vecs[16] = mk(5'b10000, 32'h00000001, 32'h00000001, 1'b1, 32'h00000000, 4'b0100);
        vecs[17] = mk(5'b10011, 32'h80000000, 32'h00000024, 1'b0, 32'hF8000000, 4'b0010);
        vecs[18] = mk(5'b10010, 32'h80000000, 32'h00000024, 1'b0, 32'h08000000, 4'b0000);
        vecs[19] = mk(5'b10001, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 4'b0010);
        vecs[20] = mk(5'b10001, 32'h00000001, 32'h0000003F, 1'b0, 32'h80000000, 4'b0010);
        vecs[21] = mk(5'b11111, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFF, 4'b0000);
        vecs[22] = mk(5'b00000, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 4'b0000);

        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Cin = 1'b0;
        bus.Card = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_F", {32'd0, bus.F}, 64'd0);
        check("reset_H", {32'd0, bus.H}, 64'd0);
        check("reset_flags", {60'd0, flags()}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Back-to-back issue: each vector is accepted while the previous result is handed off.
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), {63'd0, bus.out_valid}, 64'd1);
            check($sformatf("vec%0d_F", i), {32'd0, bus.F}, {32'd0, vecs[i].f});
            check($sformatf("vec%0d_H", i), {32'd0, bus.H}, 64'd0);
            check($sformatf("vec%0d_flags", i), {60'd0, flags()}, {60'd0, vecs[i].flg});
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("idle_after_vectors", {63'd0, bus.out_valid}, 64'd0);

        run_mul("mul_zero", 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 4'b0100);
        run_mul("mul_hi_only", 32'h00010000, 32'h00030000, 32'h00000003, 32'h00000000, 4'b0000);
        run_mul("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4'b0000);
        run_mul("mul_neg", 32'h80000000, 32'h00000003, 32'h00000001, 32'h80000000, 4'b0010);

        // Reset in the middle of a multiply discards it.
        drive(5'b10100, 32'h00000007, 32'h00000009, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy_F", {32'd0, bus.F}, 64'd0);
        check("rst_busy_H", {32'd0, bus.H}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_busy_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        drive(5'b00001, 32'h00000001, 32'h00000001, 1'b0);
        @(negedge clk);
        check("rst_add_valid", {63'd0, bus.out_valid}, 64'd1);
        check("rst_add_F", {32'd0, bus.F}, 64'd2);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Back-pressure: XOR result held while a pending AND waits.
        bus.out_ready = 1'b0;
        drive(5'b01110, 32'h0F0F0F0F, 32'hFFFF0000, 1'b0);
        @(negedge clk);
        drive(5'b01100, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_valid", k), {63'd0, bus.out_valid}, 64'd1);
            check($sformatf("hold%0d_in_ready", k), {63'd0, bus.in_ready}, 64'd0);
            check($sformatf("hold%0d_F", k), {32'd0, bus.F}, 64'h00000000F0F00F0F);
            check($sformatf("hold%0d_flags", k), {60'd0, flags()}, 64'b0010);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("handoff_and_valid", {63'd0, bus.out_valid}, 64'd1);
        check("handoff_and_F", {32'd0, bus.F}, 64'h000000000F000F00);
        check("handoff_and_flags", {60'd0, flags()}, 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("final_idle", {63'd0, bus.out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
